// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: request/response bus between control unit, sequencer and memory
interface mem_ctrl_if #(parameter int DATAWIDTH_BUS = 32);
  logic                     MEM_CTRL_Req_In;
  logic                     MEM_CTRL_Write_In;
  logic [DATAWIDTH_BUS-1:0] MEM_CTRL_Addr_InBus;
  logic [DATAWIDTH_BUS-1:0] MEM_CTRL_WrData_InBus;
  logic                     MEM_CTRL_Busy_Out;
  logic                     MEM_CTRL_Done_Out;
  logic                     MEM_CTRL_Error_Out;
  logic [DATAWIDTH_BUS-1:0] MEM_CTRL_RdData_OutBus;
  logic [DATAWIDTH_BUS-1:0] MEM_CTRL_A_OutBus;
  logic [DATAWIDTH_BUS-1:0] MEM_CTRL_B_OutBus;
  logic                     MEM_CTRL_RD_Out;
  logic                     MEM_CTRL_WR_Out;
  logic                     MEM_CTRL_ACK_In;
  logic [DATAWIDTH_BUS-1:0] MEM_CTRL_Data_InBus;
  modport slave (
    input  MEM_CTRL_Req_In, MEM_CTRL_Write_In, MEM_CTRL_Addr_InBus, MEM_CTRL_WrData_InBus,
           MEM_CTRL_ACK_In, MEM_CTRL_Data_InBus,
    output MEM_CTRL_Busy_Out, MEM_CTRL_Done_Out, MEM_CTRL_Error_Out, MEM_CTRL_RdData_OutBus,
           MEM_CTRL_A_OutBus, MEM_CTRL_B_OutBus, MEM_CTRL_RD_Out, MEM_CTRL_WR_Out
  );
  modport master (
    output MEM_CTRL_Req_In, MEM_CTRL_Write_In, MEM_CTRL_Addr_InBus, MEM_CTRL_WrData_InBus,
           MEM_CTRL_ACK_In, MEM_CTRL_Data_InBus,
    input  MEM_CTRL_Busy_Out, MEM_CTRL_Done_Out, MEM_CTRL_Error_Out, MEM_CTRL_RdData_OutBus,
           MEM_CTRL_A_OutBus, MEM_CTRL_B_OutBus, MEM_CTRL_RD_Out, MEM_CTRL_WR_Out
  );
endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl: single-access memory sequencer with four-phase ACK handshake and timeout
module mem_ctrl #(
  parameter int DATAWIDTH_BUS  = 32,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TIMEOUT_WIDTH  = 5
) (
  input  logic       MEM_CTRL_CLOCK_50,
  input  logic       MEM_CTRL_ResetInHigh_In,
  mem_ctrl_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, COMPLETE, RELEASE} state_t;
  localparam logic [TIMEOUT_WIDTH-1:0] LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);
  state_t                   state_q;
  logic [TIMEOUT_WIDTH-1:0] cnt_q;
  logic                     write_q, busy_q, done_q, error_q, rd_q, wr_q;
  logic [DATAWIDTH_BUS-1:0] rd_data_q, a_q, b_q;
  assign bus.MEM_CTRL_Busy_Out      = busy_q;
  assign bus.MEM_CTRL_Done_Out      = done_q;
  assign bus.MEM_CTRL_Error_Out     = error_q;
  assign bus.MEM_CTRL_RdData_OutBus = rd_data_q;
  assign bus.MEM_CTRL_A_OutBus      = a_q;
  assign bus.MEM_CTRL_B_OutBus      = b_q;
  assign bus.MEM_CTRL_RD_Out        = rd_q;
  assign bus.MEM_CTRL_WR_Out        = wr_q;
  always_ff @(posedge MEM_CTRL_CLOCK_50) begin
    if (MEM_CTRL_ResetInHigh_In) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      write_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      rd_data_q <= '0;
      a_q       <= '0;
      b_q       <= '0;
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
      case (state_q)
        IDLE: if (bus.MEM_CTRL_Req_In) begin
          a_q     <= bus.MEM_CTRL_Addr_InBus;
          b_q     <= bus.MEM_CTRL_WrData_InBus;
          write_q <= bus.MEM_CTRL_Write_In;
          rd_q    <= ~bus.MEM_CTRL_Write_In;
          wr_q    <= bus.MEM_CTRL_Write_In;
          busy_q  <= 1'b1;
          cnt_q   <= '0;
          state_q <= ACCESS;
        end
        // ACK wins over timeout when both land on the final strobe cycle
        ACCESS: if (bus.MEM_CTRL_ACK_In) begin
          if (!write_q) rd_data_q <= bus.MEM_CTRL_Data_InBus;
          rd_q    <= 1'b0;
          wr_q    <= 1'b0;
          done_q  <= 1'b1;
          state_q <= COMPLETE;
        end else if (cnt_q == LAST) begin
          rd_q    <= 1'b0;
          wr_q    <= 1'b0;
          done_q  <= 1'b1;
          error_q <= 1'b1;
          state_q <= COMPLETE;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
        COMPLETE: begin
          cnt_q   <= '0;
          busy_q  <= bus.MEM_CTRL_ACK_In;
          state_q <= bus.MEM_CTRL_ACK_In ? RELEASE : IDLE;
        end
        RELEASE: if (!bus.MEM_CTRL_ACK_In) begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed accesses against a handshaking memory model, Done responses scoreboarded
module tb_mem_ctrl;
  localparam int DW = 32;
  typedef struct packed {logic err; logic [DW-1:0] rdata;} exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  exp_t q[$];
  bit ack_en = 1'b0;
  bit idle_ack = 1'b0;
  int ack_delay = 1;
  int ack_hold = 0;
  logic [DW-1:0] rdata_m = '0;
  always #5 clk = ~clk;
  mem_ctrl_if #(.DATAWIDTH_BUS(DW)) m();
  mem_ctrl #(.DATAWIDTH_BUS(DW), .TIMEOUT_CYCLES(16), .TIMEOUT_WIDTH(5)) dut (
    .MEM_CTRL_CLOCK_50(clk),
    .MEM_CTRL_ResetInHigh_In(rst),
    .bus(m.slave)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // scoreboard monitor: every Done pulse must match the oldest queued expectation
  always @(negedge clk) begin
    exp_t e;
    if (m.MEM_CTRL_Done_Out === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=1 required=0");
      end else begin
        e = q.pop_front();
        check("done_error", 64'(m.MEM_CTRL_Error_Out), 64'(e.err));
        check("done_rdata", 64'(m.MEM_CTRL_RdData_OutBus), 64'(e.rdata));
      end
    end
  end

  // memory model: ACK on the ack_delay-th strobe cycle, released ack_hold cycles after strobe drops
  initial begin : mem_model
    int wc;
    int hc;
    wc = 0;
    hc = 0;
    m.MEM_CTRL_ACK_In = 1'b0;
    m.MEM_CTRL_Data_InBus = '0;
    forever begin
      @(negedge clk);
      if (m.MEM_CTRL_RD_Out || m.MEM_CTRL_WR_Out) begin
        wc++;
        if (ack_en && wc == ack_delay) begin
          m.MEM_CTRL_ACK_In = 1'b1;
          m.MEM_CTRL_Data_InBus = rdata_m;
        end
      end else begin
        wc = 0;
        if (!ack_en) begin
          m.MEM_CTRL_ACK_In = idle_ack;
          m.MEM_CTRL_Data_InBus = 32'h5555_AAAA;
        end else if (m.MEM_CTRL_ACK_In) begin
          if (hc == ack_hold) begin
            m.MEM_CTRL_ACK_In = 1'b0;
            hc = 0;
          end else hc++;
        end
      end
    end
  end

  task automatic access(input logic wr, input logic [DW-1:0] addr, input logic [DW-1:0] wd,
                        input logic exp_err, input logic [DW-1:0] exp_rd, input int exp_strobe,
                        input int exp_tail, input bit pulse_rel);
    int rdc, wrc, dc, tail, n;
    rdc = 0; wrc = 0; dc = 0; tail = 0; n = 0;
    q.push_back({exp_err, exp_rd});
    m.MEM_CTRL_Write_In = wr;
    m.MEM_CTRL_Addr_InBus = addr;
    m.MEM_CTRL_WrData_InBus = wd;
    m.MEM_CTRL_Req_In = 1'b1;
    @(negedge clk);
    m.MEM_CTRL_Req_In = 1'b0;
    check("busy_start", 64'(m.MEM_CTRL_Busy_Out), 64'(1));
    check("a_bus", 64'(m.MEM_CTRL_A_OutBus), 64'(addr));
    check("b_bus", 64'(m.MEM_CTRL_B_OutBus), 64'(wd));
    while (m.MEM_CTRL_Busy_Out === 1'b1 && n < 100) begin
      n++;
      if (m.MEM_CTRL_RD_Out && m.MEM_CTRL_WR_Out) begin
        checks++;
        errors++;
        $display("FAIL rd_wr_overlap actual=11 required=not both");
      end
      rdc += int'(m.MEM_CTRL_RD_Out);
      wrc += int'(m.MEM_CTRL_WR_Out);
      if (m.MEM_CTRL_Done_Out) dc++;
      if (dc > 0) tail++;
      if (pulse_rel) m.MEM_CTRL_Req_In = (dc > 0 && tail == 2);
      @(negedge clk);
    end
    m.MEM_CTRL_Req_In = 1'b0;
    check("busy_drop_in_time", 64'(n < 100), 64'(1));
    check("rd_cycles", 64'(rdc), 64'(wr ? 0 : exp_strobe));
    check("wr_cycles", 64'(wrc), 64'(wr ? exp_strobe : 0));
    check("done_count", 64'(dc), 64'(1));
    check("busy_after_done", 64'(tail), 64'(exp_tail));
  endtask

  initial begin
    m.MEM_CTRL_Req_In = 1'b0;
    m.MEM_CTRL_Write_In = 1'b0;
    m.MEM_CTRL_Addr_InBus = '0;
    m.MEM_CTRL_WrData_InBus = '0;
    repeat (2) @(negedge clk);
    check("reset_ctrl", 64'({m.MEM_CTRL_Busy_Out, m.MEM_CTRL_Done_Out, m.MEM_CTRL_Error_Out,
                             m.MEM_CTRL_RD_Out, m.MEM_CTRL_WR_Out}), 64'(0));
    check("reset_buses", {m.MEM_CTRL_A_OutBus, m.MEM_CTRL_B_OutBus}, 64'(0));
    check("reset_rdata", 64'(m.MEM_CTRL_RdData_OutBus), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    idle_ack = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_ack_busy", 64'(m.MEM_CTRL_Busy_Out), 64'(0));
    check("idle_ack_rd", 64'(m.MEM_CTRL_RD_Out), 64'(0));
    check("idle_ack_rdata", 64'(m.MEM_CTRL_RdData_OutBus), 64'(0));
    idle_ack = 1'b0;
    @(negedge clk);
    ack_en = 1'b1;
    ack_delay = 4; ack_hold = 0; rdata_m = 32'hDEAD_BEEF;
    access(1'b0, 32'h10, 32'h0, 1'b0, 32'hDEAD_BEEF, 4, 1, 1'b0);
    @(negedge clk);
    ack_delay = 2; rdata_m = 32'hBAD0_BAD0;
    access(1'b1, 32'h20, 32'h1234_5678, 1'b0, 32'hDEAD_BEEF, 2, 1, 1'b0);
    @(negedge clk);
    ack_en = 1'b0;
    access(1'b0, 32'h30, 32'h0, 1'b1, 32'hDEAD_BEEF, 16, 1, 1'b0);
    @(negedge clk);
    ack_en = 1'b1;
    ack_delay = 16; rdata_m = 32'hCAFE_F00D;
    access(1'b0, 32'h34, 32'h0, 1'b0, 32'hCAFE_F00D, 16, 1, 1'b0);
    @(negedge clk);
    ack_delay = 2; ack_hold = 4; rdata_m = 32'h0BAD_CAFE;
    access(1'b0, 32'h38, 32'h0, 1'b0, 32'h0BAD_CAFE, 2, 5, 1'b1);
    repeat (4) begin
      check("no_second_access", 64'({m.MEM_CTRL_Busy_Out, m.MEM_CTRL_RD_Out, m.MEM_CTRL_WR_Out}), 64'(0));
      @(negedge clk);
    end
    ack_hold = 0;
    ack_en = 1'b0;
    m.MEM_CTRL_Write_In = 1'b0;
    m.MEM_CTRL_Addr_InBus = 32'h40;
    m.MEM_CTRL_Req_In = 1'b1;
    @(negedge clk);
    m.MEM_CTRL_Req_In = 1'b0;
    @(negedge clk);
    check("pre_reset_rd", 64'(m.MEM_CTRL_RD_Out), 64'(1));
    rst = 1'b1;
    @(negedge clk);
    check("midreset_ctrl", 64'({m.MEM_CTRL_Busy_Out, m.MEM_CTRL_Done_Out, m.MEM_CTRL_Error_Out,
                                m.MEM_CTRL_RD_Out, m.MEM_CTRL_WR_Out}), 64'(0));
    check("midreset_rdata", 64'(m.MEM_CTRL_RdData_OutBus), 64'(0));
    rst = 1'b0;
    repeat (2) @(negedge clk);
    ack_en = 1'b1;
    ack_delay = 1; rdata_m = 32'h1357_9BDF;
    access(1'b0, 32'h44, 32'hFFFF_0000, 1'b0, 32'h1357_9BDF, 1, 1, 1'b0);
    repeat (3) @(negedge clk);
    check("scoreboard_empty", 64'(q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
